// File: rtl/mod_counter_ctrl_if.sv
// rtl/mod_counter_ctrl_if.sv - command/status bundle for the modulo counter controller
interface mod_counter_ctrl_if #(
    parameter int WIDTH = 3,
    parameter int CYC_W = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic [WIDTH-1:0] mod_in;
    logic [CYC_W-1:0] cycles_in;
    logic [WIDTH-1:0] count;
    logic [1:0]       state;
    logic             busy;
    logic             wrap;
    logic             done;
    logic             cfg_err;

    modport master (
        output start, stop, pause, mod_in, cycles_in,
        input  count, state, busy, wrap, done, cfg_err
    );

    modport slave (
        input  start, stop, pause, mod_in, cycles_in,
        output count, state, busy, wrap, done, cfg_err
    );
endinterface

// File: rtl/mod_counter_ctrl.sv
// rtl/mod_counter_ctrl.sv - start/pause/stop sequencer around a programmable modulo-N counter
module mod_counter_ctrl #(
    parameter int WIDTH = 3,
    parameter int CYC_W = 4
) (
    input logic               clk,
    input logic               rst,
    mod_counter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CYC_W-1:0] WCNT_MAX = {CYC_W{1'b1}};

    state_t           st_q, st_nx;
    logic [WIDTH-1:0] count_q, count_nx;
    logic [WIDTH-1:0] n_q, n_nx;
    logic [CYC_W-1:0] c_q, c_nx;
    logic [CYC_W-1:0] wcnt_q, wcnt_nx, wcnt_inc;
    logic             wrap_q, wrap_nx;
    logic             cfg_err_q, cfg_err_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q      <= IDLE;
            count_q   <= '0;
            n_q       <= '0;
            c_q       <= '0;
            wcnt_q    <= '0;
            wrap_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            st_q      <= st_nx;
            count_q   <= count_nx;
            n_q       <= n_nx;
            c_q       <= c_nx;
            wcnt_q    <= wcnt_nx;
            wrap_q    <= wrap_nx;
            cfg_err_q <= cfg_err_nx;
        end
    end

    // Saturation only matters for continuous runs; bounded runs hit C first.
    assign wcnt_inc = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + CYC_W'(1);

    always_comb begin
        st_nx      = st_q;
        count_nx   = count_q;
        n_nx       = n_q;
        c_nx       = c_q;
        wcnt_nx    = wcnt_q;
        wrap_nx    = 1'b0;
        cfg_err_nx = 1'b0;
        case (st_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.mod_in >= WIDTH'(2)) begin
                        n_nx     = bus.mod_in;
                        c_nx     = bus.cycles_in;
                        wcnt_nx  = '0;
                        count_nx = '0;
                        st_nx    = RUN;
                    end else begin
                        cfg_err_nx = 1'b1;
                    end
                end
            end
            RUN, PAUSE: begin
                if (bus.stop) begin
                    st_nx    = IDLE;
                    count_nx = '0;
                    wcnt_nx  = '0;
                end else if (bus.pause) begin
                    st_nx = PAUSE;
                end else begin
                    st_nx = RUN;
                    if (count_q == n_q - WIDTH'(1)) begin
                        count_nx = '0;
                        wrap_nx  = 1'b1;
                        wcnt_nx  = wcnt_inc;
                        if (c_q != '0 && wcnt_inc == c_q) begin
                            st_nx = DONE;
                        end
                    end else begin
                        count_nx = count_q + WIDTH'(1);
                    end
                end
            end
            DONE: begin
                st_nx    = IDLE;
                count_nx = '0;
                wcnt_nx  = '0;
            end
            default: begin
                st_nx = IDLE;
            end
        endcase
    end

    // Status decodes come straight from state flops, so no input reaches an output.
    assign bus.count   = count_q;
    assign bus.state   = st_q;
    assign bus.busy    = (st_q == RUN) || (st_q == PAUSE);
    assign bus.done    = (st_q == DONE);
    assign bus.wrap    = wrap_q;
    assign bus.cfg_err = cfg_err_q;
endmodule

// File: doc/mod_counter_ctrl.md
# mod_counter_ctrl

Sequencing controller for the lab's modulo counters. It owns a programmable modulo-N count register and a wrap counter, and runs them under a start/pause/stop command interface. Each run is either a fixed number of full count periods or continuous. It replaces free-running fixed-modulus counters wherever a host FSM or testbench needs to launch, suspend, abort and observe completion of a counting run.

## Interface
Parameters:
- WIDTH, 3, width of the count register; legal modulus is 2 .. 2^WIDTH-1
- CYC_W, 4, width of the run-length (wrap count) field

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- start  in  1  level, sampled each edge; launches a run when in IDLE
- stop  in  1  level; aborts a run and returns to IDLE
- pause  in  1  level; freezes the count while high
- mod_in  in  WIDTH  modulus N, latched on accepted start
- cycles_in  in  CYC_W  number of full periods to run, latched on accepted start; 0 = continuous
- count  out  WIDTH  current count, 0 .. N-1
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
- busy  out  1  high in RUN or PAUSE
- wrap  out  1  one-cycle pulse, high in the cycle count returns from N-1 to 0
- done  out  1  high exactly while state==DONE (one cycle)
- cfg_err  out  1  one-cycle pulse, high when a start is rejected for mod_in<2

## Operation
- Reset (rst=0, asynchronous): state=IDLE, count=0, wrap=0, done=0, cfg_err=0, busy=0, latched mod/cycles/wrap counter=0. Reset takes effect immediately, including mid-run. Operation resumes on the first rising edge after rst=1.
- Command priority at every edge: stop > pause > advance. start is only examined in IDLE and is ignored in all other states.
- IDLE:
  - start=1 with mod_in>=2: latch N=mod_in and C=cycles_in, clear the wrap counter, go to RUN, count=0.
  - start=1 with mod_in<2: cfg_err=1 for one cycle, stay in IDLE.
- RUN/PAUSE, stop=1: go to IDLE, count=0, wrap counter=0, no done and no wrap pulse.
- RUN/PAUSE, stop=0, pause=1: go to or stay in PAUSE. count and the wrap counter hold.
- RUN/PAUSE, stop=0, pause=0: go to RUN and advance. Resume from PAUSE takes no extra bubble.
- Advance:
  - If count<N-1, count+1.
  - If count==N-1, count=0, wrap=1, and the wrap counter increments.
  - If C!=0 and the incremented wrap counter equals C, state goes to DONE.
  - If C==0, the run is continuous. The wrap counter saturates at 2^CYC_W-1 and has no further effect.
- DONE: count=0, done=1. Next edge goes unconditionally to IDLE. A start in DONE is ignored.
- Width rules: count compares against the latched N-1 only. mod_in changes during a run have no effect. count never exceeds N-1.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Accepted start at edge k: state=RUN, count=0 after k; count=1 after k+1.
- One period takes N cycles. With C periods, the wrap pulse and DONE occur after edge k+N*C, and IDLE follows after edge k+N*C+1. Pause cycles add one cycle each.
- wrap and the transition to DONE occur on the same edge for the final period.
- stop and pause sampled at edge k take effect in the state/count visible after k.
- Simultaneous stop and pause: stop wins. A stop on the final-wrap edge goes to IDLE with no done and no wrap pulse.
- Back-to-back runs: with start held high, a new run is accepted on the edge after DONE→IDLE, so the minimum gap is 1 IDLE cycle.

## Test plan
- Reset: drive rst=0 mid-run at count=4 -> count, state, wrap, done and busy all go to 0 immediately without a clock edge.
- mod_in=7, cycles_in=1, 1-cycle start -> count 0,1,2,3,4,5,6 on successive cycles, then 0 with wrap=1 and done=1 (state=3), then state=0. Exactly 7 RUN cycles.
- mod_in=5, cycles_in=3 -> three wrap pulses 5 cycles apart, done on the third, total RUN time 15 cycles.
- mod_in=7, cycles_in=0 -> continuous count for 30 cycles with no done. Then stop=1 -> count=0, state=IDLE, no done.
- Pause: mod_in=6, pause high for 4 cycles at count=3 -> state=2 and count frozen at 3 for 4 cycles, then resume at 4. Done is delayed by exactly 4 cycles.
- Corner cases:
  - start with mod_in=1 -> cfg_err pulse, state stays 0.
  - stop and pause together in RUN -> IDLE.
  - mod_in changed mid-run from 7 to 3 -> count still reaches 6.
